// File: rtl/aq_dtu_pcfifo_mc.sv
`default_nettype none
// aq_dtu_pcfifo_mc: debug trace buffer of retired change-of-flow target PCs, read via CP0 0xfe2/0xfe3.
// Define AQ_DTU_PCFIFO_TSTAMP_EN to store a 16-bit "cycles since previous write" stamp with each entry.

module gated_clk_cell (
   input  logic clk_in,
   input  logic global_en,
   input  logic module_en,
   input  logic local_en,
   input  logic pad_yy_icg_scan_en,
   output logic clk_out
);
   logic en_lat;

   always_latch begin
      if (!clk_in) en_lat = (global_en & (module_en | local_en)) | pad_yy_icg_scan_en;
   end

   assign clk_out = clk_in & en_lat;
endmodule

module aq_dtu_pcfifo_mc #(
   parameter int PA_WIDTH = 40,
   parameter int DEPTH    = 16,
   parameter int PTR_W    = 4,
   parameter int RETIRE_W = 2,
   parameter int DATAW    = 64
) (
   input  logic                         forever_cpuclk,
   input  logic                         cpurst_b,
   input  logic                         cp0_yy_clk_en,
   input  logic                         cp0_dtu_icg_en,
   input  logic                         pad_yy_icg_scan_en,
   input  logic                         cp0_dtu_rreg,
   input  logic [11:0]                  cp0_dtu_addr,
   input  logic                         cp0_dtu_pcfifo_frz,
   input  logic                         cp0_dtu_pcfifo_clr,
   input  logic                         rtu_dtu_halt_ack,
   input  logic [RETIRE_W-1:0]          rtu_dtu_retire_vld,
   input  logic [RETIRE_W-1:0]          rtu_dtu_retire_chgflw,
   input  logic [RETIRE_W*PA_WIDTH-1:0] rtu_dtu_retire_next_pc,
   output logic [PA_WIDTH-1:0]          latest_pc,
   output logic [DATAW-1:0]             pcfifo_regs_data,
   output logic [DATAW-1:0]             pcfifo_status_data,
   output logic                         pcfifo_ovf
);
   localparam int              CW        = PTR_W + 1;
   localparam int              SW        = PTR_W + 2;
   localparam logic [SW-1:0]   DEPTH_S   = SW'(DEPTH);
   localparam logic [CW-1:0]   DEPTH_C   = CW'(DEPTH);
   localparam logic [11:0]     ADDR_DATA = 12'hfe2;

   logic [PA_WIDTH-1:0] entry_q [DEPTH];
   logic [PTR_W-1:0]    wptr_q, wptr_d, rptr_q;
   logic [CW-1:0]       cnt_q, cnt_d, rd_rem_q;
   logic                ovf_q, ovf_d, first_q;

   logic [PA_WIDTH-1:0] slot_pc  [RETIRE_W];
   logic [PTR_W-1:0]    slot_idx [RETIRE_W];
   logic [RETIRE_W-1:0] wr_vec;
   logic [PTR_W-1:0]    nw;
   logic [SW-1:0]       cnt_sum;
   logic [PA_WIDTH-1:0] wr_pc_young;
   logic [DATAW-1:0]    rd_word;
   logic                wr_any, rd_hit, rd_go, gclk;

   // A clear in the same cycle drops any retiring writes.
   assign wr_vec = rtu_dtu_retire_vld & rtu_dtu_retire_chgflw
                 & {RETIRE_W{~cp0_dtu_pcfifo_frz & ~cp0_dtu_pcfifo_clr}};
   assign wr_any = |wr_vec;
   assign rd_hit = cp0_dtu_rreg & (cp0_dtu_addr == ADDR_DATA);
   assign rd_go  = rd_hit & (rd_rem_q != '0);

   always_comb begin
      nw          = '0;
      wr_pc_young = '0;
      for (int i = 0; i < RETIRE_W; i++) begin
         slot_pc[i]  = rtu_dtu_retire_next_pc[i*PA_WIDTH +: PA_WIDTH];
         slot_idx[i] = wptr_q + nw;
         if (wr_vec[i]) begin
            nw          = nw + PTR_W'(1);
            wr_pc_young = slot_pc[i];
         end
      end
   end

   assign wptr_d  = wptr_q + nw;
   assign cnt_sum = {1'b0, cnt_q} + {2'b00, nw};
   assign cnt_d   = (cnt_sum > DEPTH_S) ? DEPTH_C : cnt_sum[CW-1:0];
   assign ovf_d   = ovf_q | (cnt_sum > DEPTH_S);

   gated_clk_cell x_pcfifo_gateclk (
      .clk_in             (forever_cpuclk),
      .global_en          (cp0_yy_clk_en),
      .module_en          (cp0_dtu_icg_en),
      .local_en           (wr_any | rd_hit | rtu_dtu_halt_ack | cp0_dtu_pcfifo_clr),
      .pad_yy_icg_scan_en (pad_yy_icg_scan_en),
      .clk_out            (gclk)
   );

`ifdef AQ_DTU_PCFIFO_TSTAMP_EN
   logic [15:0] ts_q;
   logic [15:0] ts_ent_q [DEPTH];

   // Runs on the free clock so idle cycles are counted while the buffer is gated off.
   always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
      if (!cpurst_b) begin
         ts_q <= '0;
      end else if (cp0_dtu_pcfifo_clr | wr_any) begin
         ts_q <= '0;
      end else if (ts_q != 16'hffff) begin
         ts_q <= ts_q + 16'd1;
      end
   end

   assign rd_word = DATAW'({ts_ent_q[rptr_q], 48'($signed(entry_q[rptr_q]))});
`else
   assign rd_word = DATAW'($signed(entry_q[rptr_q]));
`endif

   always_ff @(posedge gclk or negedge cpurst_b) begin
      if (!cpurst_b) begin
         for (int e = 0; e < DEPTH; e++) begin
            entry_q[e] <= '0;
`ifdef AQ_DTU_PCFIFO_TSTAMP_EN
            ts_ent_q[e] <= '0;
`endif
         end
      end else begin
         for (int i = 0; i < RETIRE_W; i++) begin
            if (wr_vec[i]) begin
               entry_q[slot_idx[i]] <= slot_pc[i];
`ifdef AQ_DTU_PCFIFO_TSTAMP_EN
               ts_ent_q[slot_idx[i]] <= ts_q;
`endif
            end
         end
      end
   end

   always_ff @(posedge gclk or negedge cpurst_b) begin
      if (!cpurst_b) begin
         wptr_q   <= '0;
         rptr_q   <= '0;
         cnt_q    <= '0;
         rd_rem_q <= '0;
         ovf_q    <= 1'b0;
         first_q  <= 1'b0;
      end else if (cp0_dtu_pcfifo_clr) begin
         wptr_q   <= '0;
         rptr_q   <= '0;
         cnt_q    <= '0;
         rd_rem_q <= '0;
         ovf_q    <= 1'b0;
      end else begin
         wptr_q <= wptr_d;
         cnt_q  <= cnt_d;
         ovf_q  <= ovf_d;
         if (rtu_dtu_halt_ack) begin
            // Oldest valid entry, counting writes retiring in this same cycle.
            rptr_q   <= wptr_d - cnt_d[PTR_W-1:0];
            rd_rem_q <= cnt_d;
            first_q  <= 1'b1;
         end else if (rd_go) begin
            first_q <= 1'b0;
            if (!cp0_dtu_pcfifo_frz) begin
               rptr_q   <= rptr_q + PTR_W'(1);
               rd_rem_q <= rd_rem_q - CW'(1);
            end
         end
      end
   end

   always_comb begin
      pcfifo_regs_data = '0;
      if (rd_go) begin
         pcfifo_regs_data    = rd_word;
         pcfifo_regs_data[0] = rd_word[0] | first_q;
      end
   end

   always_comb begin
      pcfifo_status_data        = '0;
      pcfifo_status_data[31]    = ovf_q;
      pcfifo_status_data[23:16] = 8'(rd_rem_q);
      pcfifo_status_data[7:0]   = 8'(cnt_q);
   end

   assign latest_pc  = wr_any ? wr_pc_young
                     : (cnt_q != '0) ? entry_q[wptr_q - PTR_W'(1)] : '0;
   assign pcfifo_ovf = ovf_q;
endmodule
`default_nettype wire

// File: tb/tb_aq_dtu_pcfifo_mc.sv
`default_nettype none
// tb_aq_dtu_pcfifo_mc: directed scenarios plus randomized traffic checked against an integer/array model.
module tb_aq_dtu_pcfifo_mc;
   localparam int PA    = 40;
   localparam int DEPTH = 16;
   localparam int RW    = 2;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          clk_en, icg_en, scan_en, rreg, frz, clr, halt;
   logic [11:0]   addr;
   logic [1:0]    vld, chg;
   logic [79:0]   npc;
   logic [39:0]   latest_pc;
   logic [63:0]   regs_data, status_data;
   logic          ovf;

   int checks   = 0;
   int failures = 0;

   logic [39:0] m_mem [DEPTH];
`ifdef AQ_DTU_PCFIFO_TSTAMP_EN
   logic [15:0] m_tsm [DEPTH];
`endif
   int m_wp, m_rp, m_cnt, m_rem, m_ts;
   bit m_ovf, m_first;

   aq_dtu_pcfifo_mc dut (
      .forever_cpuclk         (clk),
      .cpurst_b               (rst_n),
      .cp0_yy_clk_en          (clk_en),
      .cp0_dtu_icg_en         (icg_en),
      .pad_yy_icg_scan_en     (scan_en),
      .cp0_dtu_rreg           (rreg),
      .cp0_dtu_addr           (addr),
      .cp0_dtu_pcfifo_frz     (frz),
      .cp0_dtu_pcfifo_clr     (clr),
      .rtu_dtu_halt_ack       (halt),
      .rtu_dtu_retire_vld     (vld),
      .rtu_dtu_retire_chgflw  (chg),
      .rtu_dtu_retire_next_pc (npc),
      .latest_pc              (latest_pc),
      .pcfifo_regs_data       (regs_data),
      .pcfifo_status_data     (status_data),
      .pcfifo_ovf             (ovf)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic model_reset();
      for (int e = 0; e < DEPTH; e++) begin
         m_mem[e] = '0;
`ifdef AQ_DTU_PCFIFO_TSTAMP_EN
         m_tsm[e] = '0;
`endif
      end
      m_wp = 0; m_rp = 0; m_cnt = 0; m_rem = 0; m_ts = 0; m_ovf = 0; m_first = 0;
   endtask

   task automatic set_idle();
      rreg = 0; addr = 12'h0; frz = 0; clr = 0; halt = 0; vld = 0; chg = 0; npc = '0;
   endtask

   // Advance the model by one clock using the current inputs, then step the DUT.
   task automatic tick();
      int n = 0;
      for (int i = 0; i < RW; i++) begin
         if (vld[i] && chg[i] && !frz && !clr) begin
            m_mem[(m_wp + n) % DEPTH] = npc[i*PA +: PA];
`ifdef AQ_DTU_PCFIFO_TSTAMP_EN
            m_tsm[(m_wp + n) % DEPTH] = 16'(m_ts);
`endif
            n++;
         end
      end
      if (clr) begin
         m_wp = 0; m_rp = 0; m_cnt = 0; m_rem = 0; m_ovf = 0;
      end else begin
         m_wp = (m_wp + n) % DEPTH;
         if (m_cnt + n > DEPTH) m_ovf = 1;
         m_cnt = (m_cnt + n > DEPTH) ? DEPTH : m_cnt + n;
         if (halt) begin
            m_rp = (m_wp - m_cnt + DEPTH) % DEPTH;
            m_rem = m_cnt;
            m_first = 1;
         end else if (rreg && addr == 12'hfe2 && m_rem != 0) begin
            m_first = 0;
            if (!frz) begin
               m_rp = (m_rp + 1) % DEPTH;
               m_rem--;
            end
         end
      end
      m_ts = (clr || n > 0) ? 0 : ((m_ts < 65535) ? m_ts + 1 : m_ts);
      @(posedge clk);
      #1;
   endtask

   function automatic logic [63:0] m_word(input int idx);
      logic [63:0] w;
      w = {{24{m_mem[idx][39]}}, m_mem[idx]};
`ifdef AQ_DTU_PCFIFO_TSTAMP_EN
      w[63:48] = m_tsm[idx];
`endif
      return w;
   endfunction

   function automatic logic [63:0] m_regs();
      if (!(rreg && addr == 12'hfe2) || m_rem == 0) return 64'h0;
      return m_word(m_rp) | {63'h0, m_first};
   endfunction

   function automatic logic [63:0] m_status();
      return {32'h0, m_ovf, 7'h0, 8'(m_rem), 8'h0, 8'(m_cnt)};
   endfunction

   function automatic logic [39:0] m_latest();
      logic [39:0] r;
      r = (m_cnt != 0) ? m_mem[(m_wp + DEPTH - 1) % DEPTH] : 40'h0;
      if (!frz && !clr)
         for (int i = 0; i < RW; i++)
            if (vld[i] && chg[i]) r = npc[i*PA +: PA];
      return r;
   endfunction

   task automatic test_reset();
      rreg = 1; addr = 12'hfe2; #1;
      checks++; if (regs_data !== 64'h0) begin failures++; $display("FAIL reset_regs: got %h want 0", regs_data); end
      checks++; if (status_data !== 64'h0) begin failures++; $display("FAIL reset_status: got %h want 0", status_data); end
      checks++; if (latest_pc !== 40'h0) begin failures++; $display("FAIL reset_latest: got %h want 0", latest_pc); end
      checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL reset_ovf: got %b want 0", ovf); end
      set_idle(); tick();
   endtask

   task automatic test_dual_write();
      clr = 1; tick(); set_idle();
      vld = 2'b11; chg = 2'b11; npc = {40'h80000200, 40'h80000100}; #1;
      checks++; if (latest_pc !== 40'h80000200) begin failures++; $display("FAIL dual_latest: got %h want 80000200", latest_pc); end
      tick(); set_idle();
      rreg = 1; addr = 12'hfe3; #1;
      checks++; if (status_data !== 64'h2) begin failures++; $display("FAIL dual_cnt: got %h want 2", status_data); end
      rreg = 0; halt = 1; tick(); set_idle();
      rreg = 1; addr = 12'hfe2; #1;
      checks++; if (regs_data !== 64'h80000101) begin failures++; $display("FAIL dual_rd0: got %h want 80000101", regs_data); end
      tick(); #1;
      checks++; if (regs_data !== 64'h80000200) begin failures++; $display("FAIL dual_rd1: got %h want 80000200", regs_data); end
      tick(); #1;
      checks++; if (regs_data !== 64'h0) begin failures++; $display("FAIL dual_rd2: got %h want 0", regs_data); end
      tick(); addr = 12'hfe3; #1;
      checks++; if (status_data !== 64'h2) begin failures++; $display("FAIL dual_rem0: got %h want 2", status_data); end
      set_idle();
   endtask

   task automatic test_overflow();
      clr = 1; tick(); set_idle();
      for (int k = 0; k < 18; k++) begin
         vld = 0; chg = 2'b11; npc = '0;
         vld[k % 2] = 1'b1;
         npc[(k % 2)*PA +: PA] = 40'(32'h1000 + 4 * k);
         tick();
      end
      set_idle(); halt = 1; tick(); set_idle();
      rreg = 1; addr = 12'hfe3; #1;
      checks++; if (status_data !== 64'h8010_0010) begin failures++; $display("FAIL ovf_status: got %h want 80100010", status_data); end
      checks++; if (ovf !== 1'b1) begin failures++; $display("FAIL ovf_flag: got %b want 1", ovf); end
      addr = 12'hfe2;
      for (int r = 0; r < 16; r++) begin
         logic [63:0] want;
         want = 64'(32'h1000 + 4 * (r + 2));
         if (r == 0) want[0] = 1'b1;
         #1;
         checks++; if (regs_data[39:0] !== want[39:0]) begin failures++; $display("FAIL ovf_rd%0d: got %h want %h", r, regs_data, want); end
         tick();
      end
      #1;
      checks++; if (regs_data !== 64'h0) begin failures++; $display("FAIL ovf_rd_empty: got %h want 0", regs_data); end
      set_idle();
   endtask

   task automatic test_freeze();
      clr = 1; tick(); set_idle();
      for (int k = 0; k < 3; k++) begin
         vld = 2'b01; chg = 2'b01; npc = 80'(40'hA0 + 40'h10 * k); tick();
      end
      frz = 1; vld = 2'b11; chg = 2'b11; npc = 80'({$urandom, $urandom, $urandom}); #1;
      checks++; if (latest_pc !== 40'hC0) begin failures++; $display("FAIL frz_latest: got %h want c0", latest_pc); end
      repeat (3) tick();
      vld = 0; rreg = 1; addr = 12'hfe3; #1;
      checks++; if (status_data !== 64'h3) begin failures++; $display("FAIL frz_cnt: got %h want 3", status_data); end
      rreg = 0; halt = 1; tick(); halt = 0;
      rreg = 1; addr = 12'hfe2; #1;
      checks++; if (regs_data[39:1] !== 39'h50) begin failures++; $display("FAIL frz_rd0: got %h want entry a0", regs_data); end
      tick(); #1;
      checks++; if (regs_data[39:1] !== 39'h50) begin failures++; $display("FAIL frz_rd1: got %h want entry a0", regs_data); end
      tick(); addr = 12'hfe3; #1;
      checks++; if (status_data !== 64'h0003_0003) begin failures++; $display("FAIL frz_rem: got %h want 30003", status_data); end
      frz = 0; addr = 12'hfe2; #1;
      checks++; if (regs_data[39:0] !== 40'hA0) begin failures++; $display("FAIL frz_rd2: got %h want a0", regs_data); end
      tick(); #1;
      checks++; if (regs_data[39:0] !== 40'hB0) begin failures++; $display("FAIL frz_rd3: got %h want b0", regs_data); end
      tick(); set_idle();
   endtask

   task automatic test_clr_priority();
      clr = 1; tick(); set_idle();
      for (int k = 0; k < 17; k++) begin
         vld = 2'b01; chg = 2'b01; npc = 80'({$urandom, $urandom}); tick();
      end
      set_idle(); #1;
      checks++; if (ovf !== 1'b1) begin failures++; $display("FAIL clr_pre_ovf: got %b want 1", ovf); end
      vld = 2'b11; chg = 2'b11; npc = 80'({$urandom, $urandom, $urandom}); halt = 1; clr = 1;
      tick(); set_idle();
      rreg = 1; addr = 12'hfe3; #1;
      checks++; if (status_data !== 64'h0) begin failures++; $display("FAIL clr_status: got %h want 0", status_data); end
      checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL clr_ovf: got %b want 0", ovf); end
      checks++; if (latest_pc !== 40'h0) begin failures++; $display("FAIL clr_latest: got %h want 0", latest_pc); end
      set_idle();
   endtask

   task automatic test_sign_ext();
      logic [63:0] want;
`ifdef AQ_DTU_PCFIFO_TSTAMP_EN
      want = {16'd5, 48'hFFFF_FFFF_FFF1};
`else
      want = 64'hFFFF_FFFF_FFFF_FFF1;
`endif
      clr = 1; tick(); set_idle();
      repeat (5) tick();
      vld = 2'b01; chg = 2'b01; npc = 80'(40'hFF_FFFF_FFF0); tick(); set_idle();
      halt = 1; tick(); set_idle();
      rreg = 1; addr = 12'hfe2; #1;
      checks++; if (regs_data !== want) begin failures++; $display("FAIL sext_rd: got %h want %h", regs_data, want); end
      tick(); set_idle();
   endtask

   task automatic test_random();
      clr = 1; tick(); set_idle();
      for (int c = 0; c < 400; c++) begin
         int sel;
         vld  = 2'($urandom);
         chg  = 2'($urandom);
         npc  = 80'({$urandom, $urandom, $urandom});
         frz  = ($urandom_range(0, 9) == 0);
         clr  = ($urandom_range(0, 39) == 0);
         halt = ($urandom_range(0, 14) == 0);
         rreg = ($urandom_range(0, 2) != 0);
         sel  = $urandom_range(0, 9);
         addr = (sel < 7) ? 12'hfe2 : ((sel < 9) ? 12'hfe3 : 12'h7c0);
         #1;
         checks++; if (latest_pc !== m_latest()) begin failures++; $display("FAIL rnd_latest c=%0d: got %h want %h", c, latest_pc, m_latest()); end
         checks++; if (regs_data !== m_regs()) begin failures++; $display("FAIL rnd_regs c=%0d: got %h want %h", c, regs_data, m_regs()); end
         checks++; if (status_data !== m_status()) begin failures++; $display("FAIL rnd_status c=%0d: got %h want %h", c, status_data, m_status()); end
         checks++; if (ovf !== m_ovf) begin failures++; $display("FAIL rnd_ovf c=%0d: got %b want %b", c, ovf, m_ovf); end
         tick();
      end
      set_idle();
   endtask

   task automatic test_async_reset();
      clr = 1; tick(); set_idle();
      for (int k = 0; k < 5; k++) begin
         vld = 2'b10; chg = 2'b10; npc = {40'(40'h500 + 40'h8 * k), 40'h0}; tick();
      end
      set_idle(); halt = 1; tick(); set_idle();
      rreg = 1; addr = 12'hfe2;
      repeat (2) tick();
      addr = 12'hfe3; #1;
      checks++; if (status_data !== 64'h0003_0005) begin failures++; $display("FAIL arst_pre: got %h want 30005", status_data); end
      addr = 12'hfe2; #1;
      rst_n = 0; model_reset(); #1;
      checks++; if (regs_data !== 64'h0) begin failures++; $display("FAIL arst_regs: got %h want 0", regs_data); end
      checks++; if (status_data !== 64'h0) begin failures++; $display("FAIL arst_status: got %h want 0", status_data); end
      checks++; if (latest_pc !== 40'h0) begin failures++; $display("FAIL arst_latest: got %h want 0", latest_pc); end
      checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL arst_ovf: got %b want 0", ovf); end
      @(negedge clk); rst_n = 1;
      tick(); #1;
      checks++; if (regs_data !== 64'h0) begin failures++; $display("FAIL arst_read_after: got %h want 0", regs_data); end
      set_idle(); tick();
   endtask

   initial begin
      clk_en = 1; icg_en = 0; scan_en = 0;
      set_idle();
      rst_n = 0;
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1;
      test_reset();
      test_dual_write();
      test_overflow();
      test_freeze();
      test_clr_priority();
      test_sign_ext();
      test_random();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
`default_nettype wire
